alarm_clock_ctrl: RTL and testbench

Mode controller for the alarm-clock datapath. It drives the en/enHours/enMins/updown controls of the hours-minutes-seconds counter from the 1 Hz tick and debounced buttons. It holds the alarm time in internal registers, compares it against the running time and sequences the alarm-ring state. It sits between the button/tick front-end and the time counter, and feeds the display mux and LEDs.

---
 rtl/alarm_clock_ctrl_if.sv | 22 ++
 rtl/alarm_clock_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_alarm_clock_ctrl.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/alarm_clock_ctrl_if.sv
// Time-counter bus: adjust/count controls toward the counter, running BCD time back.
interface alarm_clock_ctrl_if;
  logic       en;
  logic       enHours;
  logic       enMins;
  logic       updown;
  logic [5:0] seconds;
  logic [3:0] minutes_units;
  logic [2:0] minutes_tens;
  logic [3:0] hours_units;
  logic [1:0] hours_tens;

  modport master (
    output en, enHours, enMins, updown,
    input  seconds, minutes_units, minutes_tens, hours_units, hours_tens
  );

  modport slave (
    input  en, enHours, enMins, updown,
    output seconds, minutes_units, minutes_tens, hours_units, hours_tens
  );
endinterface

// File: rtl/alarm_clock_ctrl.sv
// Alarm-clock mode controller: time/alarm adjust modes, alarm match detection
// and ring sequencing. Every output is a register.
module alarm_clock_ctrl #(
  parameter int unsigned RING_TICKS = 60
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick_1hz,
  input  logic               btn_c,
  input  logic               btn_l,
  input  logic               btn_r,
  input  logic               btn_u,
  input  logic               btn_d,
  input  logic               alarm_en,
  alarm_clock_ctrl_if.master tc,
  output logic [3:0]         alarm_minutes_units,
  output logic [2:0]         alarm_minutes_tens,
  output logic [3:0]         alarm_hours_units,
  output logic [1:0]         alarm_hours_tens,
  output logic               show_alarm,
  output logic [1:0]         edit_field,
  output logic               buzzer,
  output logic               ring_led
);

  typedef enum logic [2:0] {CLOCK, T_HR, T_MIN, A_HR, A_MIN, RING} state_t;

  state_t     state_q, state_d;
  logic [7:0] ring_cnt_q, ring_cnt_d, ring_cnt_inc;
  logic       match, match_q, match_rise;
  logic       en_q, en_d, en_hours_q, en_hours_d, en_mins_q, en_mins_d;
  logic       updown_q, updown_d, buzzer_d;
  logic       show_d, ring_d;
  logic [1:0] field_d;
  logic [5:0] alarm_hr_d;
  logic [6:0] alarm_min_d;
  logic [6:0] run_hr, run_min, al_hr, al_min;
  logic       any_btn;

  function automatic state_t adj_next(input state_t s);
    case (s)
      T_HR:    return T_MIN;
      T_MIN:   return A_HR;
      A_HR:    return A_MIN;
      default: return T_HR;
    endcase
  endfunction

  function automatic state_t adj_prev(input state_t s);
    case (s)
      T_HR:    return A_MIN;
      T_MIN:   return T_HR;
      A_HR:    return T_MIN;
      default: return A_HR;
    endcase
  endfunction

  // BCD step of the alarm hours, wrapping 23 <-> 00.
  function automatic logic [5:0] hr_step(input logic [1:0] t, input logic [3:0] u,
                                         input logic up);
    logic [1:0] nt;
    logic [3:0] nu;
    nt = t;
    nu = u;
    if (up) begin
      if (t == 2'd2 && u == 4'd3) begin nt = '0; nu = '0; end
      else if (u == 4'd9)         begin nt = t + 2'd1; nu = '0; end
      else                        nu = u + 4'd1;
    end else begin
      if (t == '0 && u == '0)     begin nt = 2'd2; nu = 4'd3; end
      else if (u == '0)           begin nt = t - 2'd1; nu = 4'd9; end
      else                        nu = u - 4'd1;
    end
    return {nt, nu};
  endfunction

  // BCD step of the alarm minutes, wrapping 59 <-> 00.
  function automatic logic [6:0] min_step(input logic [2:0] t, input logic [3:0] u,
                                          input logic up);
    logic [2:0] nt;
    logic [3:0] nu;
    nt = t;
    nu = u;
    if (up) begin
      if (t == 3'd5 && u == 4'd9) begin nt = '0; nu = '0; end
      else if (u == 4'd9)         begin nt = t + 3'd1; nu = '0; end
      else                        nu = u + 4'd1;
    end else begin
      if (t == '0 && u == '0)     begin nt = 3'd5; nu = 4'd9; end
      else if (u == '0)           begin nt = t - 3'd1; nu = 4'd9; end
      else                        nu = u - 4'd1;
    end
    return {nt, nu};
  endfunction

  assign run_hr  = 7'(tc.hours_tens) * 7'd10 + 7'(tc.hours_units);
  assign run_min = 7'(tc.minutes_tens) * 7'd10 + 7'(tc.minutes_units);
  assign al_hr   = 7'(alarm_hours_tens) * 7'd10 + 7'(alarm_hours_units);
  assign al_min  = 7'(alarm_minutes_tens) * 7'd10 + 7'(alarm_minutes_units);

  // match_q is updated in every state, so a match already present when
  // CLOCK is re-entered produces no rising edge.
  assign match        = (run_hr == al_hr) && (run_min == al_min) && (tc.seconds == '0);
  assign match_rise   = match && !match_q;
  assign any_btn      = btn_c | btn_l | btn_r | btn_u | btn_d;
  assign ring_cnt_inc = ring_cnt_q + {7'd0, tick_1hz};

  always_comb begin
    state_d     = state_q;
    ring_cnt_d  = ring_cnt_q;
    en_d        = tick_1hz && (state_q == CLOCK || state_q == RING);
    en_hours_d  = 1'b0;
    en_mins_d   = 1'b0;
    updown_d    = updown_q;
    buzzer_d    = buzzer;
    alarm_hr_d  = {alarm_hours_tens, alarm_hours_units};
    alarm_min_d = {alarm_minutes_tens, alarm_minutes_units};
    case (state_q)
      CLOCK: begin
        if (match_rise && alarm_en) begin
          state_d    = RING;
          buzzer_d   = 1'b1;
          ring_cnt_d = '0;
        end else if (btn_c) begin
          state_d = T_HR;
        end
      end
      RING: begin
        if (any_btn || !alarm_en || ring_cnt_inc == 8'(RING_TICKS)) begin
          state_d    = CLOCK;
          buzzer_d   = 1'b0;
          ring_cnt_d = '0;
        end else begin
          ring_cnt_d = ring_cnt_inc;
          if (tick_1hz) buzzer_d = !buzzer;
        end
      end
      default: begin
        // l/r together consumes the cycle without moving; u/d together is ignored.
        if (btn_c) begin
          state_d = CLOCK;
        end else if (btn_l || btn_r) begin
          if (btn_r && !btn_l)      state_d = adj_next(state_q);
          else if (btn_l && !btn_r) state_d = adj_prev(state_q);
        end else if (btn_u != btn_d) begin
          case (state_q)
            T_HR:    begin en_hours_d = 1'b1; updown_d = btn_u; end
            T_MIN:   begin en_mins_d  = 1'b1; updown_d = btn_u; end
            A_HR:    alarm_hr_d  = hr_step(alarm_hours_tens, alarm_hours_units, btn_u);
            default: alarm_min_d = min_step(alarm_minutes_tens, alarm_minutes_units, btn_u);
          endcase
        end
      end
    endcase
    show_d  = (state_d == A_HR) || (state_d == A_MIN);
    ring_d  = (state_d == RING);
    field_d = (state_d == T_HR || state_d == A_HR)  ? 2'b01 :
              (state_d == T_MIN || state_d == A_MIN) ? 2'b10 : 2'b00;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q             <= CLOCK;
      ring_cnt_q          <= '0;
      match_q             <= 1'b0;
      en_q                <= 1'b0;
      en_hours_q          <= 1'b0;
      en_mins_q           <= 1'b0;
      updown_q            <= 1'b1;
      buzzer              <= 1'b0;
      ring_led            <= 1'b0;
      show_alarm          <= 1'b0;
      edit_field          <= '0;
      alarm_hours_tens    <= '0;
      alarm_hours_units   <= '0;
      alarm_minutes_tens  <= '0;
      alarm_minutes_units <= '0;
    end else begin
      state_q             <= state_d;
      ring_cnt_q          <= ring_cnt_d;
      match_q             <= match;
      en_q                <= en_d;
      en_hours_q          <= en_hours_d;
      en_mins_q           <= en_mins_d;
      updown_q            <= updown_d;
      buzzer              <= buzzer_d;
      ring_led            <= ring_d;
      show_alarm          <= show_d;
      edit_field          <= field_d;
      {alarm_hours_tens, alarm_hours_units}     <= alarm_hr_d;
      {alarm_minutes_tens, alarm_minutes_units} <= alarm_min_d;
    end
  end

  assign tc.en      = en_q;
  assign tc.enHours = en_hours_q;
  assign tc.enMins  = en_mins_q;
  assign tc.updown  = updown_q;

endmodule

// File: tb/tb_alarm_clock_ctrl.sv
// Directed bench for alarm_clock_ctrl: an abstract mode/alarm model checked every
// cycle, plus literal expectations at key points of each scenario.
module tb_alarm_clock_ctrl;
  localparam int RT = 4;
  localparam logic [5:0] TK = 6'b100000, BC = 6'b010000, BL = 6'b001000,
                         BR = 6'b000100, BU = 6'b000010, BD = 6'b000001;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic alarm_en = 1'b0;
  logic [5:0] stim = '0;
  logic tick_1hz, btn_c, btn_l, btn_r, btn_u, btn_d;
  logic [3:0] alarm_minutes_units, alarm_hours_units;
  logic [2:0] alarm_minutes_tens;
  logic [1:0] alarm_hours_tens, edit_field;
  logic show_alarm, buzzer, ring_led;

  int checks = 0;
  int failures = 0;
  int en_cnt = 0, eh_cnt = 0, em_cnt = 0;

  alarm_clock_ctrl_if tcif ();

  assign {tick_1hz, btn_c, btn_l, btn_r, btn_u, btn_d} = stim;

  alarm_clock_ctrl #(.RING_TICKS(RT)) dut (
    .clk(clk), .reset(reset), .tick_1hz(tick_1hz),
    .btn_c(btn_c), .btn_l(btn_l), .btn_r(btn_r), .btn_u(btn_u), .btn_d(btn_d),
    .alarm_en(alarm_en), .tc(tcif.master),
    .alarm_minutes_units(alarm_minutes_units), .alarm_minutes_tens(alarm_minutes_tens),
    .alarm_hours_units(alarm_hours_units), .alarm_hours_tens(alarm_hours_tens),
    .show_alarm(show_alarm), .edit_field(edit_field), .buzzer(buzzer), .ring_led(ring_led)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic set_time(input int h, input int m, input int s);
    tcif.hours_tens    = 2'(h / 10);
    tcif.hours_units   = 4'(h % 10);
    tcif.minutes_tens  = 3'(m / 10);
    tcif.minutes_units = 4'(m % 10);
    tcif.seconds       = 6'(s);
  endtask

  // Inputs change 2 time units after a rising edge and last one clock.
  task automatic step(input logic [5:0] v);
    stim = v;
    @(posedge clk);
    #2;
    stim = '0;
  endtask

  // Abstract model: modes 0 clock, 1..4 adjust ring (t_hr,t_min,a_hr,a_min), 5 ringing.
  int   m_mode, m_cnt, m_ah, m_am;
  logic m_prev, m_en, m_eh, m_em, m_ud, m_buz;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_mode = 0; m_cnt = 0; m_ah = 0; m_am = 0; m_prev = 0;
      m_en = 0; m_eh = 0; m_em = 0; m_ud = 1; m_buz = 0;
    end else begin
      automatic int  th = int'(tcif.hours_tens) * 10 + int'(tcif.hours_units);
      automatic int  tm = int'(tcif.minutes_tens) * 10 + int'(tcif.minutes_units);
      automatic bit  mt = (th == m_ah) && (tm == m_am) && (tcif.seconds == 0);
      automatic bit  rise = mt && !m_prev;
      automatic bit  anyb = btn_c | btn_l | btn_r | btn_u | btn_d;
      m_prev = mt;
      m_en = tick_1hz && (m_mode == 0 || m_mode == 5);
      m_eh = 0;
      m_em = 0;
      if (m_mode == 0) begin
        if (rise && alarm_en) begin m_mode = 5; m_buz = 1; m_cnt = 0; end
        else if (btn_c) m_mode = 1;
      end else if (m_mode == 5) begin
        if (tick_1hz) m_cnt++;
        if (anyb || !alarm_en || m_cnt == RT) begin m_mode = 0; m_buz = 0; m_cnt = 0; end
        else if (tick_1hz) m_buz = !m_buz;
      end else begin
        if (btn_c) m_mode = 0;
        else if (btn_l || btn_r) begin
          if (btn_r && !btn_l) m_mode = (m_mode % 4) + 1;
          else if (btn_l && !btn_r) m_mode = ((m_mode + 2) % 4) + 1;
        end else if (btn_u != btn_d) begin
          if (m_mode == 1) begin m_eh = 1; m_ud = btn_u; end
          else if (m_mode == 2) begin m_em = 1; m_ud = btn_u; end
          else if (m_mode == 3) m_ah = (m_ah + (btn_u ? 1 : 23)) % 24;
          else m_am = (m_am + (btn_u ? 1 : 59)) % 60;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("en", 8'(tcif.en), 8'(m_en));
    chk("enHours", 8'(tcif.enHours), 8'(m_eh));
    chk("enMins", 8'(tcif.enMins), 8'(m_em));
    chk("updown", 8'(tcif.updown), 8'(m_ud));
    chk("buzzer", 8'(buzzer), 8'(m_buz));
    chk("ring_led", 8'(ring_led), 8'(m_mode == 5));
    chk("show_alarm", 8'(show_alarm), 8'(m_mode == 3 || m_mode == 4));
    chk("edit_field", 8'(edit_field),
        (m_mode == 1 || m_mode == 3) ? 8'd1 : (m_mode == 2 || m_mode == 4) ? 8'd2 : 8'd0);
    chk("alarm_hr", 8'(alarm_hours_tens) * 8'd10 + 8'(alarm_hours_units), 8'(m_ah));
    chk("alarm_min", 8'(alarm_minutes_tens) * 8'd10 + 8'(alarm_minutes_units), 8'(m_am));
    if (tcif.en) en_cnt++;
    if (tcif.enHours) eh_cnt++;
    if (tcif.enMins) em_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    set_time(12, 34, 56);
    repeat (3) @(posedge clk);
    #2;
    chk("rst_updown", 8'(tcif.updown), 8'd1);
    chk("rst_en", 8'(tcif.en), 8'd0);
    chk("rst_alarm", {alarm_hours_tens, alarm_hours_units, 2'b00}, 8'd0);
    reset = 1'b1;
    step('0);

    en_cnt = 0; eh_cnt = 0; em_cnt = 0;
    repeat (3) begin step(TK); step('0); step('0); end
    chk("three_ticks_en", 8'(en_cnt), 8'd3);
    chk("clock_no_adj", 8'(eh_cnt + em_cnt), 8'd0);

    en_cnt = 0;
    step(BC);
    chk("thr_field", 8'(edit_field), 8'd1);
    step(BU); step(BU); step(BR);
    chk("tmin_field", 8'(edit_field), 8'd2);
    step(BD); step(TK); step('0);
    chk("thr_pulses", 8'(eh_cnt), 8'd2);
    chk("tmin_pulses", 8'(em_cnt), 8'd1);
    chk("updown_down", 8'(tcif.updown), 8'd0);
    chk("frozen_en", 8'(en_cnt), 8'd0);

    step(BR);
    chk("ahr_show", 8'(show_alarm), 8'd1);
    step(BD);
    chk("ahr_wrap_tens", 8'(alarm_hours_tens), 8'd2);
    chk("ahr_wrap_units", 8'(alarm_hours_units), 8'd3);
    step(BR);
    for (int i = 0; i < 61; i++) step(BU);
    chk("amin_tens", 8'(alarm_minutes_tens), 8'd0);
    chk("amin_units", 8'(alarm_minutes_units), 8'd1);
    chk("amin_show", 8'(show_alarm), 8'd1);
    step(BL | BR);
    chk("lr_nomove", 8'(edit_field), 8'd2);
    step(BU | BD);
    chk("ud_noadj", 8'(alarm_minutes_units), 8'd1);
    for (int i = 0; i < 29; i++) step(BU);
    step(BL);
    for (int i = 0; i < 8; i++) step(BU);
    chk("alarm_0730_h", {alarm_hours_tens, 2'b00, alarm_hours_units}, 8'h07);
    chk("alarm_0730_m", {1'b0, alarm_minutes_tens, alarm_minutes_units}, 8'h30);
    step(BC);
    chk("back_clock_show", 8'(show_alarm), 8'd0);

    alarm_en = 1'b1;
    set_time(7, 29, 59); step('0);
    set_time(7, 30, 0);  step('0);
    chk("ring_enter", 8'(ring_led), 8'd1);
    chk("ring_buz1", 8'(buzzer), 8'd1);
    step(TK);
    chk("ring_buz2", 8'(buzzer), 8'd0);
    step('0); step(TK);
    chk("ring_buz3", 8'(buzzer), 8'd1);
    step(TK);
    chk("ring_still", 8'(ring_led), 8'd1);
    step(TK);
    chk("ring_timeout", 8'(ring_led), 8'd0);
    chk("ring_timeout_buz", 8'(buzzer), 8'd0);
    set_time(7, 30, 1); step('0);

    alarm_en = 1'b0;
    set_time(7, 29, 59); step('0);
    set_time(7, 30, 0);  step('0); step('0);
    chk("disarmed_no_ring", 8'(ring_led), 8'd0);
    set_time(7, 31, 0); step('0);
    alarm_en = 1'b1;
    step(BC); step(BR);
    set_time(7, 29, 59); step('0);
    set_time(7, 30, 0);  step('0); step('0);
    chk("tmin_no_ring", 8'(ring_led), 8'd0);
    step(BC); step('0); step('0);
    chk("late_match_no_ring", 8'(ring_led), 8'd0);

    set_time(7, 30, 1); step('0);
    set_time(7, 30, 0); step('0);
    chk("ring_again", 8'(ring_led), 8'd1);
    eh_cnt = 0; em_cnt = 0;
    step(BU); step('0);
    chk("btn_silence", 8'(ring_led), 8'd0);
    chk("silence_no_adj", 8'(eh_cnt + em_cnt), 8'd0);
    chk("silence_updown", 8'(tcif.updown), 8'd0);

    set_time(7, 30, 1); step('0);
    set_time(7, 30, 0);
    step(BC);
    chk("ring_beats_c", 8'(ring_led), 8'd1);
    chk("ring_beats_c_fld", 8'(edit_field), 8'd0);
    step(TK);
    #1 reset = 1'b0;
    #1;
    chk("arst_ring", 8'(ring_led), 8'd0);
    chk("arst_buz", 8'(buzzer), 8'd0);
    chk("arst_updown", 8'(tcif.updown), 8'd1);
    chk("arst_alarm_h", 8'(alarm_hours_units), 8'd0);
    chk("arst_alarm_m", 8'(alarm_minutes_tens), 8'd0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    step('0); step(TK); step('0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
